// File: rtl/mcu51_serial_pkg.sv
// Purpose : shared types and constants for the MCU51 mode-1 serial port.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: TX/RX state enums, default bit period and its counter width.
package mcu51_serial_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // Default clock cycles per serial bit and the counter width it needs.
    localparam int BIT_TICKS_DEF = 16;
    localparam int BIT_CNT_W     = $clog2(BIT_TICKS_DEF);

endpackage

// File: rtl/mcu51_bit_timer.sv
// Purpose : per-FSM bit-period counter, 0..TICKS-1, with synchronous load.
// Latency : ticks are combinational from the registered count.
// Backpressure: none; counts whenever i_en is high.
// Ports   : i_clk, i_reset (sync, active-high), i_load (clear count),
//           i_en (advance), o_tick_mid (count == TICKS/2-1),
//           o_tick_end (count == TICKS-1, last cycle of the bit).
module mcu51_bit_timer
    import mcu51_serial_pkg::*;
#(
    parameter int TICKS = BIT_TICKS_DEF,
    parameter int W     = BIT_CNT_W
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_tick_mid,
    output logic o_tick_end
);

    localparam logic [W-1:0] END_V = W'(TICKS - 1);
    localparam logic [W-1:0] MID_V = W'(TICKS / 2 - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_load) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == END_V) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tick_mid = i_en && (r_cnt == MID_V);
    assign o_tick_end = i_en && (r_cnt == END_V);

endmodule

// File: rtl/mcu51_serial_port.sv
// Purpose : 8N1 mode-1 serial port (SBUF/SCON style) for the MCU51 SFR bus.
// Latency : txd goes low one edge after sbuf_wr; ri one edge after stop sample.
// Backpressure: sbuf_wr while a frame is in progress is dropped; RX bytes
//           completing while ri=1 are dropped and flagged in o_rx_ovr.
// Ports   : i_clk, i_reset (sync, active-high), i_sbuf_wr/i_wdata (TX write),
//           i_ti_clr, i_ri_clr (flag clears), i_ren (RX enable), i_rxd (async),
//           o_txd, o_rdata, o_ti, o_ri, o_tx_busy, o_rx_ovr, o_rx_fe.
module mcu51_serial_port
    import mcu51_serial_pkg::*;
#(
    parameter int BIT_TICKS = BIT_TICKS_DEF
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_sbuf_wr,
    input  logic [7:0] i_wdata,
    input  logic       i_ti_clr,
    input  logic       i_ri_clr,
    input  logic       i_ren,
    input  logic       i_rxd,
    output logic       o_txd,
    output logic [7:0] o_rdata,
    output logic       o_ti,
    output logic       o_ri,
    output logic       o_tx_busy,
    output logic       o_rx_ovr,
    output logic       o_rx_fe
);

    localparam int CNT_W = $clog2(BIT_TICKS);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_e  r_tx_state, w_tx_nxt;
    logic [7:0] r_tx_sh;
    logic [2:0] r_tx_bit;
    logic       r_ti;
    logic       w_tx_load, w_tx_accept, w_tx_shift, w_ti_set;
    logic       w_tx_end, w_tx_mid_unused;
    logic       w_tx_en;

    assign w_tx_en = (r_tx_state != TX_IDLE);

    mcu51_bit_timer #(.TICKS(BIT_TICKS), .W(CNT_W)) u_tx_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_tx_load),
        .i_en       (w_tx_en),
        .o_tick_mid (w_tx_mid_unused),
        .o_tick_end (w_tx_end)
    );

    always_comb begin
        w_tx_nxt    = r_tx_state;
        w_tx_load   = 1'b0;
        w_tx_accept = 1'b0;
        w_tx_shift  = 1'b0;
        w_ti_set    = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (i_sbuf_wr) begin
                    w_tx_nxt    = TX_START;
                    w_tx_load   = 1'b1;
                    w_tx_accept = 1'b1;
                end
            end
            TX_START: begin
                if (w_tx_end) begin
                    w_tx_nxt  = TX_DATA;
                    w_tx_load = 1'b1;
                end
            end
            TX_DATA: begin
                if (w_tx_end) begin
                    w_tx_shift = 1'b1;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_nxt  = TX_STOP;
                        w_tx_load = 1'b1;
                    end
                end
            end
            TX_STOP: begin
                if (w_tx_end) begin
                    w_ti_set  = 1'b1;
                    w_tx_load = 1'b1;
                    // A write landing on the completion cycle chains straight
                    // into the next start bit.
                    if (i_sbuf_wr) begin
                        w_tx_nxt    = TX_START;
                        w_tx_accept = 1'b1;
                    end else begin
                        w_tx_nxt = TX_IDLE;
                    end
                end
            end
            default: w_tx_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_sh    <= 8'h00;
            r_tx_bit   <= 3'd0;
            r_ti       <= 1'b0;
        end else begin
            r_tx_state <= w_tx_nxt;
            if (w_tx_accept) begin
                r_tx_sh  <= i_wdata;
                r_tx_bit <= 3'd0;
            end else if (w_tx_shift) begin
                r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
                r_tx_bit <= r_tx_bit + 3'd1;
            end
            // Set wins over a coincident clear.
            if (w_ti_set)      r_ti <= 1'b1;
            else if (i_ti_clr) r_ti <= 1'b0;
        end
    end

    always_comb begin
        case (r_tx_state)
            TX_START: o_txd = 1'b0;
            TX_DATA:  o_txd = r_tx_sh[0];
            default:  o_txd = 1'b1;
        endcase
    end

    assign o_ti      = r_ti;
    assign o_tx_busy = (r_tx_state != TX_IDLE);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_e  r_rx_state, w_rx_nxt;
    logic       r_rxd_m, r_rxd_s, r_rxd_d;
    logic [7:0] r_rx_sh;
    logic [2:0] r_rx_bit;
    logic [7:0] r_rdata;
    logic       r_ri, r_ovr, r_fe;
    logic       w_rx_load, w_rx_start, w_rx_shift, w_rx_done;
    logic       w_rx_mid, w_rx_end, w_rx_en;
    logic       w_ri_set, w_ovr_set, w_fe_set;

    assign w_rx_en = (r_rx_state != RX_IDLE);

    mcu51_bit_timer #(.TICKS(BIT_TICKS), .W(CNT_W)) u_rx_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_rx_load),
        .i_en       (w_rx_en),
        .o_tick_mid (w_rx_mid),
        .o_tick_end (w_rx_end)
    );

    always_comb begin
        w_rx_nxt   = r_rx_state;
        w_rx_load  = 1'b0;
        w_rx_start = 1'b0;
        w_rx_shift = 1'b0;
        w_rx_done  = 1'b0;
        if (!i_ren && (r_rx_state != RX_IDLE)) begin
            w_rx_nxt = RX_IDLE;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (i_ren && r_rxd_d && !r_rxd_s) begin
                        w_rx_nxt   = RX_START;
                        w_rx_load  = 1'b1;
                        w_rx_start = 1'b1;
                    end
                end
                RX_START: begin
                    // Mid start bit: reload so every later tick_end is mid-bit.
                    if (w_rx_mid) begin
                        if (r_rxd_s) begin
                            w_rx_nxt = RX_IDLE;
                        end else begin
                            w_rx_nxt  = RX_DATA;
                            w_rx_load = 1'b1;
                        end
                    end
                end
                RX_DATA: begin
                    if (w_rx_end) begin
                        w_rx_shift = 1'b1;
                        if (r_rx_bit == 3'd7) begin
                            w_rx_nxt  = RX_STOP;
                            w_rx_load = 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    if (w_rx_end) begin
                        w_rx_done = 1'b1;
                        w_rx_nxt  = RX_IDLE;
                    end
                end
                default: w_rx_nxt = RX_IDLE;
            endcase
        end
    end

    assign w_ri_set  = w_rx_done &&  r_rxd_s && !r_ri;
    assign w_ovr_set = w_rx_done &&  r_rxd_s &&  r_ri;
    assign w_fe_set  = w_rx_done && !r_rxd_s;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rxd_m    <= 1'b1;
            r_rxd_s    <= 1'b1;
            r_rxd_d    <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_sh    <= 8'h00;
            r_rx_bit   <= 3'd0;
            r_rdata    <= 8'h00;
            r_ri       <= 1'b0;
            r_ovr      <= 1'b0;
            r_fe       <= 1'b0;
        end else begin
            r_rxd_m    <= i_rxd;
            r_rxd_s    <= r_rxd_m;
            r_rxd_d    <= r_rxd_s;
            r_rx_state <= w_rx_nxt;
            if (w_rx_start) begin
                r_rx_bit <= 3'd0;
            end else if (w_rx_shift) begin
                // LSB arrives first, so shift in from the top.
                r_rx_sh  <= {r_rxd_s, r_rx_sh[7:1]};
                r_rx_bit <= r_rx_bit + 3'd1;
            end
            if (w_ri_set) r_rdata <= r_rx_sh;
            if (w_ri_set)      r_ri <= 1'b1;
            else if (i_ri_clr) r_ri <= 1'b0;
            if (w_ovr_set)     r_ovr <= 1'b1;
            else if (i_ri_clr) r_ovr <= 1'b0;
            if (w_fe_set)      r_fe <= 1'b1;
            else if (i_ri_clr) r_fe <= 1'b0;
        end
    end

    assign o_rdata  = r_rdata;
    assign o_ri     = r_ri;
    assign o_rx_ovr = r_ovr;
    assign o_rx_fe  = r_fe;

endmodule

// File: tb/tb_mcu51_serial_port.sv
// Purpose : self-checking bench for mcu51_serial_port (TX, RX, loopback, flags).
// Latency : n/a.
// Backpressure: n/a.
module tb_mcu51_serial_port;

    logic       clk = 1'b0;
    logic       reset, sbuf_wr, ti_clr, ri_clr, ren, rxd_drv, loop_en;
    logic [7:0] wdata;
    logic       rxd, txd, ti, ri, tx_busy, rx_ovr, rx_fe;
    logic [7:0] rdata;

    int checks = 0;
    int errors = 0;

    logic       tx_q[$];
    logic [7:0] rx_q[$];

    assign rxd = loop_en ? txd : rxd_drv;

    always #5 clk = ~clk;

    mcu51_serial_port #(.BIT_TICKS(16)) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_sbuf_wr (sbuf_wr),
        .i_wdata   (wdata),
        .i_ti_clr  (ti_clr),
        .i_ri_clr  (ri_clr),
        .i_ren     (ren),
        .i_rxd     (rxd),
        .o_txd     (txd),
        .o_rdata   (rdata),
        .o_ti      (ti),
        .o_ri      (ri),
        .o_tx_busy (tx_busy),
        .o_rx_ovr  (rx_ovr),
        .o_rx_fe   (rx_fe)
    );

    task automatic pulse_ti_clr();
        @(negedge clk); ti_clr = 1'b1;
        @(negedge clk); ti_clr = 1'b0;
    endtask

    task automatic pulse_ri_clr();
        @(negedge clk); ri_clr = 1'b1;
        @(negedge clk); ri_clr = 1'b0;
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
        rxd_drv = 1'b0;
        repeat (16) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rxd_drv = b[k];
            repeat (16) @(negedge clk);
        end
        rxd_drv = stop_bit;
        repeat (16) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_ri(input int lim, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < lim; c++) begin
            if (ri === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Expected bit stream is queued at the write and popped per bit period.
    // ti_clr is pulsed on the set edge to confirm set beats clear.
    task automatic tx_frame_check(input logic [7:0] b, input bit inject);
        tx_q.delete();
        tx_q.push_back(1'b0);
        for (int k = 0; k < 8; k++) tx_q.push_back(b[k]);
        tx_q.push_back(1'b1);
        @(negedge clk); sbuf_wr = 1'b1; wdata = b;
        @(negedge clk); sbuf_wr = 1'b0;
        for (int i = 0; i <= 160; i++) begin
            if (i < 160) begin
                checks++;
                if (txd !== tx_q[0]) begin
                    errors++;
                    $display("FAIL tx_bit byte=%h cyc=%0d got=%b exp=%b", b, i, txd, tx_q[0]);
                end
                checks++;
                if (tx_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL tx_busy_high cyc=%0d got=%b exp=1", i, tx_busy);
                end
                checks++;
                if (ti !== 1'b0) begin
                    errors++;
                    $display("FAIL ti_early cyc=%0d got=%b exp=0", i, ti);
                end
                if (i % 16 == 15) void'(tx_q.pop_front());
            end else begin
                checks++;
                if (ti !== 1'b1 || tx_busy !== 1'b0 || txd !== 1'b1) begin
                    errors++;
                    $display("FAIL tx_done ti=%b busy=%b txd=%b exp ti=1 busy=0 txd=1", ti, tx_busy, txd);
                end
            end
            ti_clr  = (i == 159);
            sbuf_wr = inject && (i == 40);
            wdata   = (inject && (i == 40)) ? 8'h3C : b;
            @(negedge clk);
        end
        ti_clr  = 1'b0;
        sbuf_wr = 1'b0;
        checks++;
        if (tx_q.size() != 0) begin
            errors++;
            $display("FAIL tx_queue left=%0d exp=0", tx_q.size());
        end
    endtask

    task automatic test_reset();
        checks++;
        if (txd !== 1'b1 || rdata !== 8'h00 || ti !== 1'b0 || ri !== 1'b0 ||
            tx_busy !== 1'b0 || rx_ovr !== 1'b0 || rx_fe !== 1'b0) begin
            errors++;
            $display("FAIL reset_state txd=%b rdata=%h ti=%b ri=%b busy=%b ovr=%b fe=%b exp 1 00 0 0 0 0 0",
                     txd, rdata, ti, ri, tx_busy, rx_ovr, rx_fe);
        end
    endtask

    task automatic test_tx_single();
        tx_frame_check(8'hA5, 1'b0);
    endtask

    task automatic test_tx_busy_ignore();
        int bad;
        pulse_ti_clr();
        tx_frame_check(8'hA5, 1'b1);
        pulse_ti_clr();
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (txd !== 1'b1 || tx_busy !== 1'b0 || ti !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL tx_ignored_write bad_cycles=%0d exp=0", bad);
        end
    endtask

    task automatic test_loopback();
        bit ok;
        logic [7:0] exp;
        loop_en = 1'b1;
        ren = 1'b1;
        repeat (4) @(negedge clk);
        rx_q.push_back(8'h5A);
        @(negedge clk); sbuf_wr = 1'b1; wdata = 8'h5A;
        @(negedge clk); sbuf_wr = 1'b0;
        wait_ri(400, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL loop_ri_timeout got=0 exp=1");
        end else begin
            exp = rx_q.pop_front();
            checks++;
            if (rdata !== exp) begin
                errors++;
                $display("FAIL loop_rdata got=%h exp=%h", rdata, exp);
            end
        end
        repeat (40) @(negedge clk);
        pulse_ri_clr();
        checks++;
        if (ri !== 1'b0) begin
            errors++;
            $display("FAIL loop_ri_clr got=%b exp=0", ri);
        end
        pulse_ti_clr();
        loop_en = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_overrun();
        bit ok;
        logic [7:0] exp;
        ren = 1'b1;
        rx_q.push_back(8'h11);
        drive_frame(8'h11, 1'b1);
        wait_ri(50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ovr_first_ri_timeout got=0 exp=1");
        end else begin
            exp = rx_q.pop_front();
            checks++;
            if (rdata !== exp) begin
                errors++;
                $display("FAIL ovr_first_rdata got=%h exp=%h", rdata, exp);
            end
        end
        drive_frame(8'h22, 1'b1);
        checks++;
        if (rdata !== 8'h11 || rx_ovr !== 1'b1 || ri !== 1'b1) begin
            errors++;
            $display("FAIL ovr_set rdata=%h ovr=%b ri=%b exp 11 1 1", rdata, rx_ovr, ri);
        end
        pulse_ri_clr();
        checks++;
        if (ri !== 1'b0 || rx_ovr !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear ri=%b ovr=%b exp 0 0", ri, rx_ovr);
        end
    endtask

    task automatic test_glitch_and_fe();
        bit ok;
        logic [7:0] exp;
        rxd_drv = 1'b0;
        repeat (4) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (ri !== 1'b0 || rx_fe !== 1'b0 || rx_ovr !== 1'b0) begin
            errors++;
            $display("FAIL false_start ri=%b fe=%b ovr=%b exp 0 0 0", ri, rx_fe, rx_ovr);
        end
        drive_frame(8'h77, 1'b0);
        checks++;
        if (rx_fe !== 1'b1 || ri !== 1'b0 || rdata !== 8'h11) begin
            errors++;
            $display("FAIL frame_error fe=%b ri=%b rdata=%h exp 1 0 11", rx_fe, ri, rdata);
        end
        pulse_ri_clr();
        checks++;
        if (rx_fe !== 1'b0) begin
            errors++;
            $display("FAIL fe_clear got=%b exp=0", rx_fe);
        end
        rx_q.push_back(8'h96);
        drive_frame(8'h96, 1'b1);
        wait_ri(50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rx_after_fe_timeout got=0 exp=1");
        end else begin
            exp = rx_q.pop_front();
            checks++;
            if (rdata !== exp) begin
                errors++;
                $display("FAIL rx_after_fe_rdata got=%h exp=%h", rdata, exp);
            end
        end
        pulse_ri_clr();
        ren = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int bad;
        @(negedge clk); sbuf_wr = 1'b1; wdata = 8'h00;
        @(negedge clk); sbuf_wr = 1'b0;
        repeat (70) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (txd !== 1'b1 || tx_busy !== 1'b0 || ti !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset txd=%b busy=%b ti=%b exp 1 0 0", txd, tx_busy, ti);
        end
        bad = 0;
        repeat (150) begin
            @(negedge clk);
            if (txd !== 1'b1 || ti !== 1'b0 || tx_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mid_reset_quiet bad_cycles=%0d exp=0", bad);
        end
        tx_frame_check(8'hFF, 1'b0);
    endtask

    initial begin
        reset   = 1'b1;
        sbuf_wr = 1'b0;
        wdata   = 8'h00;
        ti_clr  = 1'b0;
        ri_clr  = 1'b0;
        ren     = 1'b0;
        rxd_drv = 1'b1;
        loop_en = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_tx_single();
        test_tx_busy_ignore();
        test_loopback();
        test_overrun();
        test_glitch_and_fe();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcu51_serial_port.md
# mcu51_serial_port

Mode-1 serial port (8051 SCON/SBUF style, 8N1) that sits directly downstream of the MCU51 core's special-function-register bus and drives the P3.1/TXD and P3.0/RXD pins. The core writes a byte to start transmission and reads received bytes. It sets and clears the TI/RI flags through strobes. Bit timing comes from a fixed clock divider, so a frame is fully cycle-predictable in simulation.

## Interface
- BIT_TICKS, 16, CLK cycles per serial bit; even, ≥ 4.
- CLK  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- sbuf_wr  in  1  one-cycle strobe: core writes SBUF (start TX).
- wdata  in  8  byte to transmit, sampled when sbuf_wr=1.
- ti_clr  in  1  strobe: clear TI.
- ri_clr  in  1  strobe: clear RI, rx_ovr, rx_fe.
- ren  in  1  receive enable (SCON.REN).
- rxd  in  1  serial input (P3.0), asynchronous.
- txd  out  1  serial output (P3.1).
- rdata  out  8  last accepted received byte (SBUF read view).
- ti  out  1  transmit-complete flag.
- ri  out  1  receive-complete flag.
- tx_busy  out  1  frame in progress on txd.
- rx_ovr  out  1  sticky: byte completed while ri=1, byte dropped.
- rx_fe  out  1  sticky: stop bit sampled 0, byte dropped.

## Operation
- Reset values: txd=1, rdata=0x00, ti=0, ri=0, tx_busy=0, rx_ovr=0, rx_fe=0. Both FSMs go to IDLE; the divider is cleared.
- TX FSM: IDLE → START → DATA(0..7, LSB first) → STOP → IDLE. Each state holds txd for exactly BIT_TICKS cycles.
- TX acceptance: sbuf_wr in IDLE latches wdata into the shift register and sets tx_busy next cycle.
- TX while busy: sbuf_wr is ignored. The frame and the shift register are unaffected.
- TX completion: at the end of the last STOP cycle, ti←1 and tx_busy←0 in the same edge.
  - A sbuf_wr on that completion cycle is accepted and starts the next frame back-to-back.
- Flag precedence: set beats clear. ti_clr coinciding with the TI-set edge leaves ti=1. The same rule applies to ri_clr versus the RI set.
- RX input: rxd passes through a 2-flop synchronizer (rxd_s) before any use.
- RX FSM: IDLE → START → DATA(0..7) → STOP → IDLE.
  - IDLE waits for ren=1 and a 1→0 transition on rxd_s.
  - START waits BIT_TICKS/2 cycles, then samples. Sample=1 means a false start and a return to IDLE with no flag.
  - DATA and STOP each sample once per BIT_TICKS, at mid-bit.
- RX at STOP sample:
  - stop=1, ri=0: rdata←byte, ri←1.
  - stop=1, ri=1: rdata unchanged, rx_ovr←1.
  - stop=0: rdata unchanged, rx_fe←1.
  - The FSM returns to IDLE immediately after the stop sample; it does not wait for the full stop bit.
- ren deasserted in any RX state: abort to IDLE next edge. No flags change, rdata is unchanged.
- TX and RX are fully independent; loopback (txd tied to rxd) must work.
- reset mid-frame: txd returns to 1 the next edge; any partial RX byte is discarded.

## Timing
- TX latency: sbuf_wr at edge N puts txd=0 at edge N+1.
- TX frame length: 10·BIT_TICKS cycles. ti rises at edge N+1+10·BIT_TICKS.
- RX latency: 2 cycles synchronizer, then start detect.
  - Stop sample lands at 9.5·BIT_TICKS after start detect (within ±1 cycle).
  - ri rises the edge after the stop sample.
- Divider: per-FSM counter counting 0..BIT_TICKS-1, reloaded on every state change. No shared free-running baud counter.

## Structure
- Package mcu51_serial_pkg holds:
  - tx/rx state enums (IDLE, START, DATA, STOP);
  - the localparam for the bit-counter width, $clog2(BIT_TICKS).
- Sub-module mcu51_bit_timer: counter with load/enable that outputs tick_mid and tick_end. It is instantiated once for TX and once for RX.
- Top level holds both FSMs, shift registers, flags and the synchronizer.

## Test plan
- TX 0xA5, BIT_TICKS=16:
  - txd reads 0,1,0,1,0,0,1,0,1,1, each bit held 16 cycles;
  - tx_busy high 160 cycles;
  - ti=1 at cycle 161 after the write.
- Second sbuf_wr (0x3C) 40 cycles into the 0xA5 frame: 0xA5 frame is unaltered, no 0x3C frame follows, only one ti pulse.
- Loopback txd→rxd, ren=1, send 0x5A: ri=1 and rdata=0x5A; then ri_clr gives ri=0.
- Receive 0x11, then 0x22 without ri_clr: rdata stays 0x11, rx_ovr=1; ri_clr clears ri and rx_ovr.
- Inject a 4-cycle low glitch on rxd: false start, no flags. A frame with stop=0: rx_fe=1, ri=0.
- Assert reset at bit 3 of a TX frame: txd=1 and tx_busy=0 next edge, no ti. A following sbuf_wr 0xFF sends a clean frame.
